float_max_pool: RTL and testbench

- Streaming 1-D max-pooling stage placed directly downstream of the float ReLU stage.
- Consumes one FLOAT_WIDTH-bit float per handshake and reduces each group of WINDOW consecutive samples (or fewer, if in_last closes the group early) to its maximum.
- Presents each maximum on a registered valid/ready output port.
- Full throughput: one input per cycle when the output side is not stalled.

---
 rtl/float_max_pool.sv | 76 +++++++
 tb/tb_float_max_pool.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/float_max_pool.sv
// Streaming 1-D max-pool: reduces groups of WINDOW floats (or shorter groups closed
// by in_last) to their maximum, presented on a registered valid/ready port.
module float_max_pool #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRAC_WIDTH  = 23,
    parameter int FLOAT_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH,
    parameter int WINDOW      = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [FLOAT_WIDTH-1:0] in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLOAT_WIDTH-1:0] out,
    output logic [CNT_WIDTH-1:0]   out_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WINDOW - 1);

    logic [FLOAT_WIDTH-1:0] acc;
    logic [FLOAT_WIDTH-1:0] comb_val;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   closing;
    logic                   in_fire;

    // Sign-magnitude ordering on raw bits; ties return a, NaN/Inf are not special.
    function automatic logic [FLOAT_WIDTH-1:0] fmax(input logic [FLOAT_WIDTH-1:0] a,
                                                    input logic [FLOAT_WIDTH-1:0] b);
        logic                   sa, sb;
        logic [FLOAT_WIDTH-2:0] ma, mb;
        sa = a[FLOAT_WIDTH-1];
        sb = b[FLOAT_WIDTH-1];
        ma = a[FLOAT_WIDTH-2:0];
        mb = b[FLOAT_WIDTH-2:0];
        if (sa != sb)
            fmax = sa ? b : a;
        else if (!sa)
            fmax = (mb > ma) ? b : a;
        else
            fmax = (mb < ma) ? b : a;
    endfunction

    assign closing  = (cnt == CNT_LAST) || in_last;
    // Only a closing sample needs the output register, so only it can stall.
    assign in_ready = !(out_valid && !out_ready && closing);
    assign in_fire  = in_valid && in_ready;
    assign comb_val = (cnt == '0) ? in : fmax(acc, in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out       <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else if (in_fire && closing) begin
            // Overwrites a result leaving this same cycle: no bubble between groups.
            out       <= comb_val;
            out_count <= cnt;
            out_valid <= 1'b1;
            cnt       <= '0;
        end else begin
            if (in_fire) begin
                acc <= comb_val;
                cnt <= cnt + CNT_WIDTH'(1);
            end
            if (out_valid && out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_float_max_pool.sv
// Bench for float_max_pool: directed literal cases on a WINDOW=4 instance plus
// random streams on WINDOW=4 and WINDOW=1 instances against an ordering-key model.
module tb_float_max_pool;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv[2], ir[2], il[2], ov[2], ordy[2];
    logic [31:0] din[2], dout[2];
    logic [7:0]  dcnt[2];

    int n_cmp = 0;
    int n_err = 0;

    // Model state: current group and the single result awaiting acceptance.
    int          grp_n[2];
    logic [31:0] gmax[2];
    logic        pend_v[2];
    logic [31:0] pend_val[2];
    logic [7:0]  pend_cnt[2];

    always #5 clk = ~clk;

    float_max_pool #(.WINDOW(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_last(il[0]), .in(din[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out(dout[0]), .out_count(dcnt[0])
    );

    float_max_pool #(.WINDOW(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_last(il[1]), .in(din[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out(dout[1]), .out_count(dcnt[1])
    );

    function automatic int win(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Total order of float bit patterns: every positive (incl. +0) above every negative,
    // negatives ordered by decreasing magnitude.
    function automatic longint fkey(input logic [31:0] x);
        if (x[31])
            return longint'(32'h7FFF_FFFF) - longint'(x[30:0]);
        return longint'(32'h8000_0000) + longint'(x[30:0]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: one full model step per cycle, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic cl, exp_ir, ofire, ifire;
            if (!rst_n) begin
                grp_n[k]  = 0;
                gmax[k]   = '0;
                pend_v[k] = 1'b0;
            end else begin
                cl     = (grp_n[k] == win(k) - 1) || il[k];
                exp_ir = !(pend_v[k] && !ordy[k] && cl);
                chk($sformatf("u%0d out_valid", k), 32'(ov[k]), 32'(pend_v[k]));
                chk($sformatf("u%0d in_ready", k), 32'(ir[k]), 32'(exp_ir));
                if (pend_v[k]) begin
                    chk($sformatf("u%0d out", k), dout[k], pend_val[k]);
                    chk($sformatf("u%0d out_count", k), 32'(dcnt[k]), 32'(pend_cnt[k]));
                end
                ofire = pend_v[k] && ordy[k];
                ifire = iv[k] && exp_ir;
                if (ofire) pend_v[k] = 1'b0;
                if (ifire) begin
                    if (grp_n[k] == 0 || fkey(din[k]) > fkey(gmax[k]))
                        gmax[k] = din[k];
                    if (cl) begin
                        pend_v[k]   = 1'b1;
                        pend_val[k] = gmax[k];
                        pend_cnt[k] = 8'(grp_n[k]);
                        grp_n[k]    = 0;
                    end else begin
                        grp_n[k]++;
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge on which the sample fired.
    task automatic send(input int k, input logic [31:0] v, input logic l);
        int t = 0;
        iv[k] = 1'b1; din[k] = v; il[k] = l;
        @(negedge clk);
        while (!ir[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL u%0d send timeout: in_ready stuck at 0, expected 1", k);
        end
        @(posedge clk); #1;
        iv[k] = 1'b0; il[k] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send4(input logic [31:0] a, b, c, d);
        send(0, a, 1'b0); send(0, b, 1'b0); send(0, c, 1'b0); send(0, d, 1'b0);
    endtask

    logic [31:0] rnd_pick[8];

    initial begin
        for (int k = 0; k < 2; k++) begin
            iv[k] = 0; il[k] = 0; din[k] = '0; ordy[k] = 1;
        end
        rnd_pick = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                     32'h7FC0_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0001};
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(ov[0]), 32'd0);
        chk("reset out", dout[0], 32'h0);
        chk("reset out_count", 32'(dcnt[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        // Positive group.
        send4(32'h3F80_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F00_0000);
        chk("pos out_valid", 32'(ov[0]), 32'd1);
        chk("pos out", dout[0], 32'h4040_0000);
        chk("pos out_count", 32'(dcnt[0]), 32'd3);
        tick();
        chk("pos out_valid drop", 32'(ov[0]), 32'd0);

        // Mixed signs: +0 must beat -0 and all negatives.
        send4(32'hC000_0000, 32'h8000_0000, 32'hBF80_0000, 32'h0000_0000);
        chk("mixed out", dout[0], 32'h0000_0000);
        tick();
        send4(32'hC040_0000, 32'hBFC0_0000, 32'hC000_0000, 32'hC080_0000);
        chk("neg out", dout[0], 32'hBFC0_0000);
        tick();

        // Backpressure: 7 fire, the 8th (closing) stalls until out_ready returns.
        ordy[0] = 1'b0;
        send4(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        send(0, 32'h40A0_0000, 1'b0);
        send(0, 32'h3F80_0000, 1'b0);
        send(0, 32'h40C0_0000, 1'b0);
        iv[0] = 1'b1; din[0] = 32'h4000_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp in_ready", 32'(ir[0]), 32'd0);
            chk("bp hold out", dout[0], 32'h4080_0000);
            chk("bp hold valid", 32'(ov[0]), 32'd1);
        end
        tick();
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", 32'(ir[0]), 32'd1);
        tick();
        iv[0] = 1'b0;
        chk("bp 2nd valid", 32'(ov[0]), 32'd1);
        chk("bp 2nd out", dout[0], 32'h40C0_0000);
        chk("bp 2nd out_count", 32'(dcnt[0]), 32'd3);
        tick();
        chk("bp drain", 32'(ov[0]), 32'd0);

        // Early close with in_last, then a full group restarting from count 0.
        send(0, 32'h40A0_0000, 1'b0);
        send(0, 32'h40E0_0000, 1'b1);
        chk("last out", dout[0], 32'h40E0_0000);
        chk("last out_count", 32'(dcnt[0]), 32'd1);
        send4(32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000, 32'h3E00_0000);
        chk("after last out", dout[0], 32'h3F40_0000);
        chk("after last out_count", 32'(dcnt[0]), 32'd3);
        tick();

        // Async reset with a result pending and a partial group in flight.
        ordy[0] = 1'b0;
        send4(32'h4200_0000, 32'h4210_0000, 32'h4220_0000, 32'h4230_0000);
        send(0, 32'h4280_0000, 1'b0);
        send(0, 32'h4290_0000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(ov[0]), 32'd0);
        chk("async rst out", dout[0], 32'h0);
        #3 rst_n = 1'b1;
        tick();
        ordy[0] = 1'b1;
        send4(32'h3F80_0000, 32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000);
        chk("post rst out", dout[0], 32'h3F80_0000);
        chk("post rst out_count", 32'(dcnt[0]), 32'd3);
        tick();

        // Random streams on both instances.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                il[k]   = ($urandom_range(0, 7) == 0);
                ordy[k] = ($urandom_range(0, 3) != 0);
                din[k]  = ($urandom_range(0, 3) == 0) ? rnd_pick[$urandom_range(0, 7)]
                                                       : 32'($urandom);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            iv[k] = 0; il[k] = 0; ordy[k] = 1;
        end
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
